slab_interval_scheduler: RTL and testbench
==========================================

// Module: slab_interval_scheduler
// PURPOSE
//  Reduces the three per-axis slab intervals of a ray/AABB test to one entry and exit distance and produces the hit flag.
//  It computes tnear_max = max(tn0,tn1,tn2) and tfar_min = min(tf0,tf1,tf2), then evaluates hit.
//  All five magnitude decisions are time-multiplexed onto ONE shared pipelined FP comparator (11b exp / 9b frac).
//  Sits between the per-axis t-computation stage and the hit/result collector.
// PARAMETERS
//  W        22  MSB index of FP word (word = W+1 bits: [W:W-1] exc, [W-2] sign, [W-3:9] exp, [8:0] frac)
//  CMP_LAT  3   cycles from driving cmp_a/cmp_b until the matching cmp_gt is valid (>=1)
// PORTS
//  clk        in   1    clock
//  rst        in   1    reset, asynchronous, active-high
//  in_valid   in   1    slab set offered
//  in_ready   out  1    high only in IDLE with no result pending
//  tn0..tn2   in   W+1  per-axis entry distances
//  tf0..tf2   in   W+1  per-axis exit distances
//  cmp_a      out  W+1  shared comparator operand A
//  cmp_b      out  W+1  shared comparator operand B
//  cmp_gt     in   1    1 iff (A-B) is normal and positive (strict A>B); equal/zero -> 0
//  out_valid  out  1    result held until out_ready
//  out_ready  in   1    downstream accepts result
//  tnear_max  out  W+1  max entry distance
//  tfar_min   out  W+1  min exit distance
//  hit        out  1    ray intersects box in front of origin
//  nan_flag   out  1    any input had exc==2'b11
// BEHAVIOUR
//  Reset: in_ready=0 during rst, 1 first cycle after; out_valid/hit/nan_flag=0; tnear_max/tfar_min/cmp_a/cmp_b=0; tag pipe cleared.
//  Accept: on in_valid&in_ready. All six operands are latched and nan_flag is computed. The block then leaves IDLE.
//  Issue order (one issue per cycle max; t0 = cycle after accept):
//   C1 t0:         A=tn0,B=tn1 -> m01 = gt?tn0:tn1
//   C2 t0+1:       A=tf0,B=tf1 -> f01 = gt?tf1:tf0
//   C3 t0+L+1:     A=m01,B=tn2 -> tnear_max = gt?m01:tn2
//   C4 t0+L+2:     A=f01,B=tf2 -> tfar_min  = gt?tf2:f01
//   C5 t0+2L+3:    A=tnear_max,B=tfar_min -> g5
//  Each result is captured on the clock edge ending its issue cycle + L. L = CMP_LAT.
//  C3 and C4 issue only once C1 and C2 are captured. C5 issues only once C3 and C4 are captured.
//  hit = !g5 & !tfar_neg & !nan_flag, where tfar_neg = (tfar_min exc==01 | exc==10) & sign==1.
//  out_valid rises in cycle t0+3L+4, i.e. 3L+5 cycles after the accept cycle (14 for L=3).
//  Latency is fixed: NaN inputs still run the full sequence, and hit is forced to 0.
//  States: IDLE, C1, C2, W1, C3, C4, W2, C5, W3, DONE.
//  W1/W2/W3 exit when the tag pipe reports the last outstanding tag captured.
//  DONE holds out_valid and the outputs stable until out_ready; DONE->IDLE on out_ready. in_ready=1 in IDLE only.
//  Tag pipe: CMP_LAT-deep shift register of {valid,id[2:0]}. A captured result is used only if the tag is valid and matches the expected id.
//  Idle cycles drive cmp_a=cmp_b=0 with tag invalid.
//  Reset mid-operation: all state is cleared asynchronously. Results still in flight inside the comparator carry cleared tags and are ignored; no spurious out_valid.
//  out_ready while out_valid=0 is ignored. in_valid outside IDLE is ignored; the input is not consumed.
// STRUCTURE
//  Shared include slab_defs.vh: W default, field index localparams, EXC_ZERO=00, EXC_NORM=01, EXC_INF=10, EXC_NAN=11, state encodings, compare ids C1..C5.
//  Sub-module: cmp_tag_pipe (CMP_LAT-deep valid/id shift register, async reset). The comparator itself is instantiated by the parent.
//  FSM plus operand/result registers stay in this module.
// TESTING (FP values shown as decimal; the bench encodes them via a slab_defs helper; CMP_LAT=3)
//  tn=(1,2,3), tf=(5,4,6) -> tnear_max=3, tfar_min=4, hit=1, out_valid 14 cycles after accept.
//  tn=(1,5,2), tf=(4,6,7) -> tnear_max=5, tfar_min=4, hit=0.
//  tn=(2,2,2), tf=(2,3,3) -> tnear_max=2, tfar_min=2, hit=1 (equal is a hit).
//  tn=(-5,-4,-3), tf=(-1,-2,-0.5) -> tfar_min=-2, hit=0; any tn0=NaN -> nan_flag=1, hit=0, same latency.
//  Hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0; release -> IDLE next cycle; back-to-back slab sets accepted.
//  Assert rst at cycle 6 after accept -> all outputs 0; a new set accepted after rst -> correct result, no stale out_valid.

Source files
------------

// File: rtl/slab_interval_scheduler_pkg.sv
// Shared definitions for the slab interval scheduler: FP field codes, FSM states, compare ids.
// Word layout (default W=22): [W:W-1] exc, [W-2] sign, [W-3:9] exp, [8:0] frac.
package slab_interval_scheduler_pkg;

  localparam int unsigned SlabW    = 22;
  localparam int unsigned ExpBits  = 11;
  localparam int unsigned FracBits = 9;

  localparam logic [1:0] ExcZero = 2'b00;
  localparam logic [1:0] ExcNorm = 2'b01;
  localparam logic [1:0] ExcInf  = 2'b10;
  localparam logic [1:0] ExcNan  = 2'b11;

  typedef enum logic [3:0] {
    StIdle,
    StC1,
    StC2,
    StW1,
    StC3,
    StC4,
    StW2,
    StC5,
    StW3,
    StDone
  } slab_state_e;

  typedef enum logic [2:0] {
    CmpNone = 3'd0,
    CmpC1   = 3'd1,
    CmpC2   = 3'd2,
    CmpC3   = 3'd3,
    CmpC4   = 3'd4,
    CmpC5   = 3'd5
  } cmp_id_e;

  // Builds a default-width FP word from its fields.
  function automatic logic [SlabW:0] fp_make(input logic [1:0]          exc,
                                             input logic                sign,
                                             input logic [ExpBits-1:0]  exp,
                                             input logic [FracBits-1:0] frac);
    return {exc, sign, exp, frac};
  endfunction

endpackage

// File: rtl/slab_interval_scheduler_if.sv
// Bundle of the scheduler's handshake, operand, comparator and result signals.
interface slab_interval_scheduler_if #(
  parameter int unsigned W = 22
);

  logic       in_valid;
  logic       in_ready;
  logic [W:0] tn0;
  logic [W:0] tn1;
  logic [W:0] tn2;
  logic [W:0] tf0;
  logic [W:0] tf1;
  logic [W:0] tf2;
  logic [W:0] cmp_a;
  logic [W:0] cmp_b;
  logic       cmp_gt;
  logic       out_valid;
  logic       out_ready;
  logic [W:0] tnear_max;
  logic [W:0] tfar_min;
  logic       hit;
  logic       nan_flag;

  modport slave (
    input  in_valid, tn0, tn1, tn2, tf0, tf1, tf2, cmp_gt, out_ready,
    output in_ready, cmp_a, cmp_b, out_valid, tnear_max, tfar_min, hit, nan_flag
  );

  modport master (
    output in_valid, tn0, tn1, tn2, tf0, tf1, tf2, cmp_gt, out_ready,
    input  in_ready, cmp_a, cmp_b, out_valid, tnear_max, tfar_min, hit, nan_flag
  );

endinterface

// File: rtl/slab_interval_scheduler_cmp_tag_pipe.sv
// Tag shift register running alongside the shared comparator; the output tag lines up
// with the comparator result for the same issue.
module slab_interval_scheduler_cmp_tag_pipe
  import slab_interval_scheduler_pkg::*;
#(
  parameter int unsigned CMP_LAT = 3
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    tag_valid_i,
  input  cmp_id_e tag_id_i,
  output logic    tag_valid_o,
  output cmp_id_e tag_id_o
);

  logic [CMP_LAT-1:0]      vld_q;
  logic [CMP_LAT-1:0][2:0] id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= tag_valid_i;
      id_q[0]  <= tag_id_i;
      for (int i = 1; i < int'(CMP_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign tag_valid_o = vld_q[CMP_LAT-1];
  assign tag_id_o    = cmp_id_e'(id_q[CMP_LAT-1]);

endmodule

// File: rtl/slab_interval_scheduler.sv
// Reduces three slab intervals to tnear_max/tfar_min and a hit flag, issuing all five
// magnitude decisions through one shared, externally pipelined comparator.
module slab_interval_scheduler
  import slab_interval_scheduler_pkg::*;
#(
  parameter int unsigned W       = SlabW,
  parameter int unsigned CMP_LAT = 3
) (
  input logic                      clk,
  input logic                      rst,
  slab_interval_scheduler_if.slave bus
);

  slab_state_e     state_q, state_d;
  logic [2:0][W:0] tn_q, tf_q;
  logic [W:0]      m01_q, f01_q, tnear_q, tfar_q;
  logic            nan_q, hit_q;

  logic            iss_vld;
  cmp_id_e         iss_id;
  logic [W:0]      cmp_a, cmp_b;
  logic            cap_vld;
  cmp_id_e         cap_id;
  logic            cap_c1, cap_c4, cap_c5;
  logic            in_ready, accept, tfar_neg, any_nan;

  function automatic logic is_nan(input logic [W:0] v);
    return v[W:W-1] == ExcNan;
  endfunction

  slab_interval_scheduler_cmp_tag_pipe #(
    .CMP_LAT(CMP_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .tag_valid_i(iss_vld),
    .tag_id_i   (iss_id),
    .tag_valid_o(cap_vld),
    .tag_id_o   (cap_id)
  );

  assign cap_c1 = cap_vld && (cap_id == CmpC1);
  assign cap_c4 = cap_vld && (cap_id == CmpC4);
  assign cap_c5 = cap_vld && (cap_id == CmpC5);

  // in_ready is gated by rst so it reads 0 throughout reset.
  assign in_ready = (state_q == StIdle) && !rst;
  assign accept   = bus.in_valid && in_ready;
  assign any_nan  = is_nan(bus.tn0) || is_nan(bus.tn1) || is_nan(bus.tn2) ||
                    is_nan(bus.tf0) || is_nan(bus.tf1) || is_nan(bus.tf2);
  assign tfar_neg = ((tfar_q[W:W-1] == ExcNorm) || (tfar_q[W:W-1] == ExcInf)) && tfar_q[W-2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // C3 only needs m01, so the first wait ends on the C1 capture; f01 lands one cycle
  // later, still before C4 issues.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StC1;
      StC1:   state_d = StC2;
      StC2:   state_d = cap_c1 ? StC3 : StW1;
      StW1:   if (cap_c1) state_d = StC3;
      StC3:   state_d = StC4;
      StC4:   state_d = StW2;
      StW2:   if (cap_c4) state_d = StC5;
      StC5:   state_d = StW3;
      StW3:   if (cap_c5) state_d = StDone;
      StDone: if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmp_a   = '0;
    cmp_b   = '0;
    iss_vld = 1'b0;
    iss_id  = CmpNone;
    unique case (state_q)
      StC1: begin
        cmp_a   = tn_q[0];
        cmp_b   = tn_q[1];
        iss_vld = 1'b1;
        iss_id  = CmpC1;
      end
      StC2: begin
        cmp_a   = tf_q[0];
        cmp_b   = tf_q[1];
        iss_vld = 1'b1;
        iss_id  = CmpC2;
      end
      StC3: begin
        cmp_a   = m01_q;
        cmp_b   = tn_q[2];
        iss_vld = 1'b1;
        iss_id  = CmpC3;
      end
      StC4: begin
        cmp_a   = f01_q;
        cmp_b   = tf_q[2];
        iss_vld = 1'b1;
        iss_id  = CmpC4;
      end
      StC5: begin
        cmp_a   = tnear_q;
        cmp_b   = tfar_q;
        iss_vld = 1'b1;
        iss_id  = CmpC5;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tn_q    <= '0;
      tf_q    <= '0;
      m01_q   <= '0;
      f01_q   <= '0;
      tnear_q <= '0;
      tfar_q  <= '0;
      nan_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      if (accept) begin
        tn_q  <= {bus.tn2, bus.tn1, bus.tn0};
        tf_q  <= {bus.tf2, bus.tf1, bus.tf0};
        nan_q <= any_nan;
        hit_q <= 1'b0;
      end
      if (cap_vld) begin
        case (cap_id)
          CmpC1:   m01_q   <= bus.cmp_gt ? tn_q[0] : tn_q[1];
          CmpC2:   f01_q   <= bus.cmp_gt ? tf_q[1] : tf_q[0];
          CmpC3:   tnear_q <= bus.cmp_gt ? m01_q : tn_q[2];
          CmpC4:   tfar_q  <= bus.cmp_gt ? tf_q[2] : f01_q;
          CmpC5:   hit_q   <= !bus.cmp_gt && !tfar_neg && !nan_q;
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.cmp_a     = cmp_a;
  assign bus.cmp_b     = cmp_b;
  assign bus.out_valid = (state_q == StDone);
  assign bus.tnear_max = tnear_q;
  assign bus.tfar_min  = tfar_q;
  assign bus.hit       = hit_q;
  assign bus.nan_flag  = nan_q;

endmodule

// File: tb/tb_slab_interval_scheduler.sv
// Directed bench for slab_interval_scheduler with a 3-cycle behavioural comparator model.
module tb_slab_interval_scheduler;
  import slab_interval_scheduler_pkg::*;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;

  slab_interval_scheduler_if #(.W(22)) bus ();

  slab_interval_scheduler #(
    .W      (22),
    .CMP_LAT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ordering key: zero -> 0, normals by {exp,frac}, inf above all normals, sign negates.
  function automatic longint fp_key(input logic [22:0] v);
    longint m;
    case (v[22:21])
      2'b01:   m = longint'(v[19:0]) + 1;
      2'b10:   m = longint'(1) << 21;
      default: m = 0;
    endcase
    return v[20] ? -m : m;
  endfunction

  function automatic logic fp_gt(input logic [22:0] a, input logic [22:0] b);
    if (a[22:21] == 2'b11 || b[22:21] == 2'b11) return 1'b0;
    return fp_key(a) > fp_key(b);
  endfunction

  logic [2:0] gt_sr = 3'b000;
  always @(posedge clk) gt_sr <= {gt_sr[1:0], fp_gt(bus.cmp_a, bus.cmp_b)};
  assign bus.cmp_gt = gt_sr[2];

  function automatic logic [22:0] fpv(input logic s, input int e, input int f);
    logic [31:0] ev, fv;
    ev = e;
    fv = f;
    return fp_make(ExcNorm, s, ev[10:0], fv[8:0]);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [22:0] one, two, three, four, five, six, seven, half, nan_v;
  logic [22:0] m1, m2, m3, m4, m5, mhalf;

  task automatic drive(input logic [22:0] a0, a1, a2, b0, b1, b2);
    bus.tn0 = a0;
    bus.tn1 = a1;
    bus.tn2 = a2;
    bus.tf0 = b0;
    bus.tf1 = b1;
    bus.tf2 = b2;
  endtask

  task automatic do_set(input string tag, input logic [22:0] a0, a1, a2, b0, b1, b2,
                        input logic [22:0] en, input logic [22:0] ef, input logic eh,
                        input logic enan, input int hold);
    int cyc;
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      step();
      cyc++;
    end
    check_eq({tag, " in_ready"}, bus.in_ready, 1);
    drive(a0, a1, a2, b0, b1, b2);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 60) begin
      step();
      cyc++;
    end
    check_eq({tag, " latency"}, cyc, 14);
    check_eq({tag, " tnear"}, bus.tnear_max, en);
    check_eq({tag, " tfar"}, bus.tfar_min, ef);
    check_eq({tag, " hit"}, bus.hit, eh);
    check_eq({tag, " nan"}, bus.nan_flag, enan);
    check_eq({tag, " busy"}, bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      // Offer a different set while busy; it must not be taken.
      drive(seven, seven, seven, one, one, one);
      bus.in_valid = 1'b1;
      step();
      check_eq({tag, " hold valid"}, bus.out_valid, 1);
      check_eq({tag, " hold tnear"}, bus.tnear_max, en);
      check_eq({tag, " hold hit"}, bus.hit, eh);
      check_eq({tag, " hold in_ready"}, bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_eq({tag, " drop valid"}, bus.out_valid, 0);
    check_eq({tag, " idle ready"}, bus.in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    one   = fpv(0, 1023, 0);
    two   = fpv(0, 1024, 0);
    three = fpv(0, 1024, 256);
    four  = fpv(0, 1025, 0);
    five  = fpv(0, 1025, 128);
    six   = fpv(0, 1025, 256);
    seven = fpv(0, 1025, 384);
    half  = fpv(0, 1022, 0);
    m1    = fpv(1, 1023, 0);
    m2    = fpv(1, 1024, 0);
    m3    = fpv(1, 1024, 256);
    m4    = fpv(1, 1025, 0);
    m5    = fpv(1, 1025, 128);
    mhalf = fpv(1, 1022, 0);
    nan_v = fp_make(ExcNan, 1'b0, 11'd0, 9'd0);

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive('0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst in_ready", bus.in_ready, 0);
    check_eq("rst out_valid", bus.out_valid, 0);
    check_eq("rst hit", bus.hit, 0);
    check_eq("rst nan", bus.nan_flag, 0);
    check_eq("rst tnear", bus.tnear_max, 0);
    check_eq("rst tfar", bus.tfar_min, 0);
    check_eq("rst cmp_a", bus.cmp_a, 0);
    rst = 1'b0;
    step();
    check_eq("post rst in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_eq("stray out_ready", bus.out_valid, 0);

    do_set("basic", one, two, three, five, four, six, three, four, 1'b1, 1'b0, 0);
    do_set("miss", one, five, two, four, six, seven, five, four, 1'b0, 1'b0, 0);
    do_set("equal", two, two, two, two, three, three, two, two, 1'b1, 1'b0, 0);
    do_set("neg", m5, m4, m3, m1, m2, mhalf, m3, m2, 1'b0, 1'b0, 0);
    do_set("nan", nan_v, two, three, five, four, six, three, four, 1'b0, 1'b1, 0);
    do_set("hold", one, two, three, five, four, six, three, four, 1'b1, 1'b0, 10);
    do_set("b2b", one, five, two, four, six, seven, five, four, 1'b0, 1'b0, 0);

    // Reset in the middle of a NaN set: C4 is on the comparator at this point.
    drive(nan_v, two, three, five, four, six);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    check_eq("pre rst nan", bus.nan_flag, 1);
    check_eq("pre rst cmp_b", bus.cmp_b, six);
    rst = 1'b1;
    #1;
    check_eq("mid rst in_ready", bus.in_ready, 0);
    check_eq("mid rst out_valid", bus.out_valid, 0);
    check_eq("mid rst nan", bus.nan_flag, 0);
    check_eq("mid rst hit", bus.hit, 0);
    check_eq("mid rst cmp_a", bus.cmp_a, 0);
    check_eq("mid rst cmp_b", bus.cmp_b, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    do_set("after rst", one, two, three, five, four, six, three, four, 1'b1, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
